// File: rtl/sll_seq_shifter_if.sv
// +--------------------------------------------------------------------------+
// | sll_seq_shifter_if : request/result bundle for the sequential SLL unit   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface sll_seq_shifter_if;
  logic [31:0] in;
  logic [4:0]  shamt;
  logic        start;
  logic        busy;
  logic        result_ready;
  logic [31:0] out;
  logic        overflow;

  modport master (
    output in,
    output shamt,
    output start,
    input  busy,
    input  result_ready,
    input  out,
    input  overflow
  );

  modport slave (
    input  in,
    input  shamt,
    input  start,
    output busy,
    output result_ready,
    output out,
    output overflow
  );
endinterface

`default_nettype wire

// File: rtl/sll_seq_shifter.sv
// +--------------------------------------------------------------------------+
// | sll_seq_shifter : 32-bit logical left shifter, one binary stage per      |
// | cycle (16/8/4/2/1), fixed 5-cycle latency. Optional overflow detection   |
// | is built when macro SLL_OVERFLOW_EN is defined.                          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module sll_seq_shifter (
  input  logic             clock,
  input  logic             reset_n,
  sll_seq_shifter_if.slave bus
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_SHIFT      = 2'd1;
  localparam logic [1:0] S_DONE       = 2'd2;
  localparam logic [2:0] C_LAST_STAGE = 3'd4;

  logic [1:0]  r_state;
  logic [2:0]  r_stage;
  logic [31:0] r_work;
  logic [4:0]  r_shamt;

  logic        w_accept;
  logic        w_sel;
  logic [4:0]  w_dist;
  logic [31:0] w_next_work;

  // Stage k consumes shamt bit [4-k] with distance 16>>k, largest first.
  always_comb begin
    w_sel  = 1'b0;
    w_dist = 5'd0;
    case (r_stage)
      3'd0: begin w_sel = r_shamt[4]; w_dist = 5'd16; end
      3'd1: begin w_sel = r_shamt[3]; w_dist = 5'd8;  end
      3'd2: begin w_sel = r_shamt[2]; w_dist = 5'd4;  end
      3'd3: begin w_sel = r_shamt[1]; w_dist = 5'd2;  end
      3'd4: begin w_sel = r_shamt[0]; w_dist = 5'd1;  end
      default: begin w_sel = 1'b0; w_dist = 5'd0; end
    endcase
  end

  assign w_next_work = w_sel ? (r_work << w_dist) : r_work;
  assign w_accept    = bus.start && (r_state != S_SHIFT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_stage <= 3'd0;
      r_work  <= 32'd0;
      r_shamt <= 5'd0;
    end else if (w_accept) begin
      r_state <= S_SHIFT;
      r_stage <= 3'd0;
      r_work  <= bus.in;
      r_shamt <= bus.shamt;
    end else begin
      case (r_state)
        S_SHIFT: begin
          r_work <= w_next_work;
          if (r_stage == C_LAST_STAGE) begin
            r_state <= S_DONE;
          end else begin
            r_stage <= r_stage + 3'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out          = r_work;
  assign bus.busy         = (r_state == S_SHIFT);
  assign bus.result_ready = (r_state == S_DONE);

`ifdef SLL_OVERFLOW_EN
  logic        r_ovf;
  logic        w_lost;

  // Bits about to leave the word are the top w_dist bits of r_work.
  assign w_lost = w_sel && (|(r_work & ~(32'hFFFF_FFFF >> w_dist)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_ovf <= r_ovf | w_lost;
    end
  end

  assign bus.overflow = r_ovf;
`else
  assign bus.overflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sll_seq_shifter.sv
// Directed bench for sll_seq_shifter; expected values hand-computed.
`default_nettype none

module tb_sll_seq_shifter;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  sll_seq_shifter_if bus ();

  sll_seq_shifter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef SLL_OVERFLOW_EN
  localparam logic C_OVF_FFFF_4 = 1'b1;
`else
  localparam logic C_OVF_FFFF_4 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [4:0] s);
    bus.in    = a;
    bus.shamt = s;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Five busy cycles with operands scrambled, then DONE with the result.
  task automatic check_op(input logic [31:0] eo, input logic eov, input string tag);
    for (int i = 0; i < 5; i++) begin
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      chk({tag, "_rr_low"}, {31'd0, bus.result_ready}, 32'd0);
      bus.in    = $urandom;
      bus.shamt = 5'($urandom);
      step();
    end
    chk({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_rr"}, {31'd0, bus.result_ready}, 32'd1);
    chk({tag, "_out"}, bus.out, eo);
    chk({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, eov});
  endtask

  task automatic held(input logic [31:0] eo, input logic eov, input string tag);
    step();
    chk({tag, "_rr_pulse"}, {31'd0, bus.result_ready}, 32'd0);
    chk({tag, "_out_held"}, bus.out, eo);
    chk({tag, "_ovf_held"}, {31'd0, bus.overflow}, {31'd0, eov});
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    bus.in    = 32'hDEAD_BEEF;
    bus.shamt = 5'd3;
    bus.start = 1'b1;
    step();
    step();
    chk("rst_out",  bus.out, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_rr",   {31'd0, bus.result_ready}, 32'd0);
    chk("rst_ovf",  {31'd0, bus.overflow}, 32'd0);
    bus.start = 1'b0;
    #2 reset_n = 1'b1;
    step();

    start_op(32'h0000_0001, 5'd31);
    check_op(32'h8000_0000, 1'b0, "sh31");
    held(32'h8000_0000, 1'b0, "sh31");

    start_op(32'h1234_5678, 5'd0);
    check_op(32'h1234_5678, 1'b0, "sh0");
    held(32'h1234_5678, 1'b0, "sh0");

    start_op(32'hA5A5_A5A5, 5'd13);
    check_op(32'hB4B4_A000, 1'b0 | C_OVF_FFFF_4, "sh13");
    step();

    // Restart attempt two cycles into an operation must be ignored.
    start_op(32'h0000_000F, 5'd8);
    step();
    step();
    bus.in    = 32'hFFFF_FFFF;
    bus.shamt = 5'd1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("ign_busy", {31'd0, bus.busy}, 32'd1);
    step();
    step();
    chk("ign_rr",  {31'd0, bus.result_ready}, 32'd1);
    chk("ign_out", bus.out, 32'h0000_0F00);
    held(32'h0000_0F00, 1'b0, "ign");

    // Asynchronous abort at stage 2.
    start_op(32'h0000_0005, 5'd31);
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("abort_out",  bus.out, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    step();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_rr", {31'd0, bus.result_ready}, 32'd0);
      step();
    end
    start_op(32'h0000_0003, 5'd2);
    check_op(32'h0000_000C, 1'b0, "post_rst");
    step();

    // Overflow case followed by a back-to-back start in the DONE cycle.
    start_op(32'hFFFF_FFFF, 5'd4);
    check_op(32'hFFFF_FFF0, C_OVF_FFFF_4, "ovf4");
    start_op(32'h0000_0001, 5'd16);
    check_op(32'h0001_0000, 1'b0, "b2b");
    held(32'h0001_0000, 1'b0, "b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sll_seq_shifter.md
SLL_SEQ_SHIFTER -- requirements
Module: sll_seq_shifter

Interface
REQ-001 The block SHALL have port `clock`, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have port `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port `in`, input, 32 bits: operand to shift left logically.
REQ-004 The block SHALL have port `shamt`, input, 5 bits: shift amount, 0..31.
REQ-005 The block SHALL have port `start`, input, 1 bit: request pulse; sampled on a rising edge.
REQ-006 The block SHALL have port `busy`, output, 1 bit: high while an operation is in progress.
REQ-007 The block SHALL have port `result_ready`, output, 1 bit: single-cycle pulse marking `out` valid.
REQ-008 The block SHALL have port `out`, output, 32 bits: registered shift result.
REQ-009 The block SHALL have port `overflow`, output, 1 bit: a nonzero bit was shifted out past bit 31 (see Configuration).

Function
REQ-010 The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-011 In IDLE or DONE, `start`=1 at an edge SHALL:
- load a working register from `in`;
- load a shamt register from `shamt`;
- clear the stage counter to 0;
- clear the overflow accumulator;
- enter SHIFT.
REQ-012 In SHIFT, each edge SHALL process one stage: stage k (0..4) uses shamt bit [4-k] and distance 16>>k (16, 8, 4, 2, 1), largest first.
REQ-013 When the selected shamt bit is 1, the working register SHALL take working << distance, zero-filled from bit 0; otherwise it SHALL hold.
REQ-014 After stage 4 the FSM SHALL enter DONE.
REQ-015 Latency: `result_ready` SHALL be high exactly in the cycle after the 5th edge following the accepting edge, for one cycle only.
REQ-016 The FSM SHALL leave DONE for IDLE after one cycle, or for SHIFT if `start`=1 in that cycle.
REQ-017 `out` SHALL always equal the working register; it is valid and held from DONE until the next accepted start.
REQ-018 `busy` SHALL be 1 exactly while in SHIFT.
REQ-019 `start` SHALL be ignored while in SHIFT; no restart occurs and the operands are unchanged.
REQ-020 `in` and `shamt` SHALL be sampled only at the accepting edge; later changes SHALL have no effect.
REQ-021 The block SHALL use fixed 5-stage latency for all shamt values, including 0, with no early-out.
REQ-022 The final `out` SHALL equal (in << shamt) truncated to 32 bits.

Reset
REQ-023 `reset_n`=0 SHALL immediately, without waiting for `clock`:
- set the FSM to IDLE;
- clear the stage counter and working register;
- clear the shamt register and overflow accumulator.
REQ-024 During and after reset, outputs SHALL be `out`=0, `busy`=0, `result_ready`=0, `overflow`=0.
REQ-025 Reset asserted mid-SHIFT SHALL abort the operation; `result_ready` SHALL NOT pulse for the aborted operation.
REQ-026 After `reset_n` deasserts, the first `start` SHALL be accepted at the first rising edge on which it is sampled high.

Configuration
REQ-027 Macro `SLL_OVERFLOW_EN` defined:
- at each shifting stage, the accumulator SHALL OR in whether any of the top `distance` bits of the working register are 1;
- `overflow` SHALL equal the accumulator and is meaningful when `result_ready`=1;
- `overflow` SHALL be held with `out` until the next accepted start.
REQ-028 Macro `SLL_OVERFLOW_EN` undefined:
- the port `overflow` SHALL remain present, tied to 0;
- no accumulator logic SHALL be built;
- all other behaviour SHALL be identical.

Verification
REQ-029 in=0x00000001, shamt=31, start pulse -> `busy` high 5 cycles, `result_ready` one-cycle pulse, out=0x80000000, overflow=0.
REQ-030 in=0xFFFFFFFF, shamt=4 -> out=0xFFFFFFF0; overflow=1 with SLL_OVERFLOW_EN defined, 0 without it.
REQ-031 in=0x12345678, shamt=0 -> out=0x12345678 after the full 5-cycle latency, overflow=0.
REQ-032 Accepted start with in=0x0000000F, shamt=8, then start with in=0xFFFFFFFF, shamt=1 two cycles later -> second start ignored, out=0x00000F00.
REQ-033 `reset_n` pulsed low at stage 2 of an operation -> out=0, busy=0 immediately, no `result_ready` pulse; next start with in=0x3, shamt=2 -> out=0xC.
REQ-034 Back-to-back: start held high in the DONE cycle with in=0x1, shamt=16 -> new operation accepted without passing through IDLE, out=0x00010000 5 edges later.
